// File: rtl/enc_pkg.sv
// Shared types and constants for the quadrature encoder step controller.
// Holds the FSM state encoding, the XY pattern constants and the per-state transition helper.
package enc_pkg;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StCw1  = 3'd1,
        StCw2  = 3'd2,
        StCw3  = 3'd3,
        StCcw1 = 3'd4,
        StCcw2 = 3'd5,
        StCcw3 = 3'd6,
        StErr  = 3'd7
    } enc_state_t;

    // Debounced pair is presented as {X, Y}
    localparam logic [1:0] PAT_DETENT = 2'b00;
    localparam logic [1:0] PAT_X      = 2'b10;
    localparam logic [1:0] PAT_XY     = 2'b11;
    localparam logic [1:0] PAT_Y      = 2'b01;

    // Move within a rotation: hold on own pattern, advance, step back, anything else is illegal.
    function automatic enc_state_t step_state(
        input logic [1:0] xy,
        input logic [1:0] own_pat,
        input logic [1:0] next_pat,
        input logic [1:0] prev_pat,
        input enc_state_t cur,
        input enc_state_t nxt,
        input enc_state_t prv
    );
        enc_state_t res;
        if (xy == own_pat) begin
            res = cur;
        end else if (xy == next_pat) begin
            res = nxt;
        end else if (xy == prev_pat) begin
            res = prv;
        end else begin
            res = StErr;
        end
        return res;
    endfunction

endpackage

// File: rtl/enc_debounce.sv
// One encoder channel: 2-flop synchroniser followed by a stability-count debouncer.
// The output follows the synchronised input only after it has differed for DEBOUNCE_CYCLES cycles.
module enc_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic deb_o
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q, sync2_q;
    logic            deb_q, deb_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end

    // A return to the accepted value at any point restarts the count
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (cnt_q == CntMax) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    assign deb_o = deb_q;

endmodule

// File: rtl/enc_step_ctrl.sv
// Quadrature encoder step controller: conditions X/Y, tracks detent cycles, counts position.
// Define ENC_SATURATE_EN to make the position counter saturate instead of wrapping.
module enc_step_ctrl
    import enc_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned POS_W           = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             encInput_X,
    input  logic             encInput_Y,
    input  logic             posClear,
    output logic             stepCW,
    output logic             stepCCW,
    output logic [POS_W-1:0] position,
    output logic             seqError,
    output logic [2:0]       encState
);

    logic             x_deb, y_deb;
    logic [1:0]       xy;
    enc_state_t       state_q, state_d;
    logic             step_cw_q, step_cw_d;
    logic             step_ccw_q, step_ccw_d;
    logic             err_q, err_d;
    logic [POS_W-1:0] pos_q, pos_d;

    enc_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_x (
        .clk_i(clk),
        .rst_i(reset),
        .raw_i(encInput_X),
        .deb_o(x_deb)
    );

    enc_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_y (
        .clk_i(clk),
        .rst_i(reset),
        .raw_i(encInput_Y),
        .deb_o(y_deb)
    );

    assign xy = {x_deb, y_deb};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            step_cw_q  <= 1'b0;
            step_ccw_q <= 1'b0;
            err_q      <= 1'b0;
            pos_q      <= '0;
        end else begin
            state_q    <= state_d;
            step_cw_q  <= step_cw_d;
            step_ccw_q <= step_ccw_d;
            err_q      <= err_d;
            pos_q      <= pos_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                case (xy)
                    PAT_X:   state_d = StCw1;
                    PAT_Y:   state_d = StCcw1;
                    PAT_XY:  state_d = StErr;
                    default: state_d = StIdle;
                endcase
            end
            StCw1:  state_d = step_state(xy, PAT_X, PAT_XY, PAT_DETENT, StCw1, StCw2, StIdle);
            StCw2:  state_d = step_state(xy, PAT_XY, PAT_Y, PAT_X, StCw2, StCw3, StCw1);
            StCw3:  state_d = step_state(xy, PAT_Y, PAT_DETENT, PAT_XY, StCw3, StIdle, StCw2);
            StCcw1: state_d = step_state(xy, PAT_Y, PAT_XY, PAT_DETENT, StCcw1, StCcw2, StIdle);
            StCcw2: state_d = step_state(xy, PAT_XY, PAT_X, PAT_Y, StCcw2, StCcw3, StCcw1);
            StCcw3: state_d = step_state(xy, PAT_X, PAT_DETENT, PAT_XY, StCcw3, StIdle, StCcw2);
            StErr:  state_d = (xy == PAT_DETENT) ? StIdle : StErr;
            default: state_d = StErr;
        endcase
    end

    // Pulses and position are registered alongside the state that completes the detent
    always_comb begin
        step_cw_d  = (state_q == StCw3) && (xy == PAT_DETENT);
        step_ccw_d = (state_q == StCcw3) && (xy == PAT_DETENT);

        pos_d = pos_q;
        if (step_cw_d) begin
`ifdef ENC_SATURATE_EN
            if (pos_q != {POS_W{1'b1}}) begin
                pos_d = pos_q + POS_W'(1);
            end
`else
            pos_d = pos_q + POS_W'(1);
`endif
        end else if (step_ccw_d) begin
`ifdef ENC_SATURATE_EN
            if (pos_q != '0) begin
                pos_d = pos_q - POS_W'(1);
            end
`else
            pos_d = pos_q - POS_W'(1);
`endif
        end
        if (posClear) begin
            pos_d = '0;
        end

        // A fresh illegal transition outranks a simultaneous clear
        err_d = err_q;
        if (posClear) begin
            err_d = 1'b0;
        end
        if ((state_d == StErr) && (state_q != StErr)) begin
            err_d = 1'b1;
        end
    end

    assign stepCW   = step_cw_q;
    assign stepCCW  = step_ccw_q;
    assign position = pos_q;
    assign seqError = err_q;
    assign encState = state_q;

endmodule

// File: doc/enc_step_ctrl.md
Name: enc_step_ctrl

Overview:
- Sequencing controller for the rotary/quadrature encoder path.
- Synchronises and debounces the raw encInput_X/encInput_Y pins and holds a registered quadrature state machine.
- Emits one-cycle clockwise/counter-clockwise step pulses per full detent cycle and maintains a signed-agnostic position counter.
- Sits between the board encoder pins and the display/consumer logic.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive clk cycles a synchronised input must be stable before it is accepted (>=1).
- POS_W, 8, width of the position counter.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- encInput_X  input  1  raw encoder channel X, asynchronous to clk
- encInput_Y  input  1  raw encoder channel Y, asynchronous to clk
- posClear  input  1  synchronous clear of position, active-high
- stepCW  output  1  one-cycle pulse, completed clockwise detent
- stepCCW  output  1  one-cycle pulse, completed counter-clockwise detent
- position  output  POS_W  detent count, unsigned
- seqError  output  1  sticky flag, illegal quadrature transition seen; cleared by posClear
- encState  output  3  current FSM state encoding, for debug

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: stepCW=0, stepCCW=0, position=0, seqError=0, FSM=IDLE, sync and debounced registers=0, debounce counters=0.
- Input conditioning, per channel:
  - 2-flop synchroniser, then debounce.
  - The debounced value updates only after the synchronised value differs from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any bounce back to the current value restarts the count at 0.
  - Latency from a clean pin edge to the debounced change: 2 + DEBOUNCE_CYCLES cycles.
- The FSM evaluates the debounced pair XY. Detent = XY=00.
- States and encodings:
  - IDLE=0
  - CW1=1 (XY=10)
  - CW2=2 (11)
  - CW3=3 (01)
  - CCW1=4 (01)
  - CCW2=5 (11)
  - CCW3=6 (10)
  - ERR=7
- Transitions, registered, one per cycle:
  - IDLE: 10 -> CW1; 01 -> CCW1; 00 stay; 11 -> ERR.
  - CWn or CCWn: input equal to own pattern -> stay; next pattern in sequence -> advance; previous pattern -> step back one state (from CW1/CCW1 back = IDLE on 00).
  - Any other pattern -> ERR.
  - CW3 + 00 -> IDLE with stepCW=1 that cycle. CCW3 + 00 -> IDLE with stepCCW=1 that cycle.
  - ERR: stays until XY=00, then -> IDLE, no pulse.
  - Entering ERR sets seqError.
- Step pulses:
  - Registered, asserted exactly one cycle, in the cycle after the debounced 00 is presented.
  - stepCW and stepCCW are never both 1.
- Position:
  - Updates in the same cycle the pulse is asserted: +1 on stepCW, -1 on stepCCW, modulo 2^POS_W (wraps max->0 and 0->max).
- posClear:
  - Next cycle position=0 and seqError=0.
  - If it coincides with a step, clear wins (position=0); the pulse output is still asserted.
  - posClear does not affect the FSM.
- Reset mid-sequence: immediate return to IDLE, pulses deasserted, position 0. A partial rotation in progress is discarded.

Optional Feature:
- Macro: ENC_SATURATE_EN.
- Defined: position saturates. stepCW at 2^POS_W-1 holds the value; stepCCW at 0 holds 0. Pulses are still emitted.
- Undefined: modulo wrap as above.

Decomposition:
- Shared package enc_pkg:
  - typedef enum logic [2:0] enc_state_t with the eight states and encodings above.
  - Localparam pattern constants PAT_DETENT=2'b00, PAT_X=2'b10, PAT_XY=2'b11, PAT_Y=2'b01.
- Sub-module enc_debounce (sync + debounce for one channel, parameter DEBOUNCE_CYCLES), instantiated twice.

Test Plan (DEBOUNCE_CYCLES=4, POS_W=4):
- Reset asserted mid-CW2 with position=5 -> immediately IDLE, position=0, encState=0, no pulse.
- Clean CW sequence 00,10,11,01,00, each held 10 cycles -> single stepCW, position 0->1, first pulse 2+4+1 cycles after the final 00 pin edge.
- Three CCW sequences from position=0 -> three stepCCW pulses, position 15,14,13. With ENC_SATURATE_EN, position stays 0.
- X glitches high for 3 cycles only -> debounced X unchanged, no state change, no pulse.
- Sequence 00,10,01 -> ERR, seqError=1. Then 00 -> IDLE with no pulse. Then posClear -> seqError=0.
- Partial CW 00,10,11 then back 10,00 -> returns to IDLE with no pulse, position unchanged.
- posClear in the same cycle as stepCW at position=7 -> position=0, stepCW visible for one cycle.
